msk_share_loader: RTL

- Upstream feeder for the masked shared-state register in the MSK gadget library.
- Takes unmasked data words over a valid/ready stream and fresh randomness per word.
- Encodes each word into d Boolean shares and accumulates NWORDS words into a shared state vector in the count*d sharing layout.
- Presents the full sharing with a valid/ready handshake to the downstream register stage.

---
 rtl/msk_share_loader_pkg.sv | 19 +
 rtl/msk_share_loader_encode.sv | 27 ++
 rtl/msk_share_loader.sv | 102 ++++++++++
 3 files changed

// File: rtl/msk_share_loader_pkg.sv
// Shared types and helpers for the masked share loader and its encoder.
package msk_share_loader_pkg;

  typedef enum logic {
    StLoad = 1'b0,
    StFull = 1'b1
  } state_e;

  // Flat position of share s of logical bit b in a d-share sharing.
  function automatic int unsigned idx(input int unsigned b, input int unsigned s,
                                      input int unsigned d);
    return b * d + s;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/msk_share_loader_encode.sv
// Boolean masking encoder: one unmasked word plus d-1 random words -> W*d shares, bit-interleaved.
(* fv_prop = "encoder", fv_strat = "isolate" *)
module msk_share_loader_encode
  import msk_share_loader_pkg::*;
#(
  parameter int unsigned d = 2,
  parameter int unsigned W = 8
) (
  input  logic [W-1:0]                                          i_data,
  (* fv_type = "random", fv_count = 1, fv_rnd_count_0 = W * (d - 1) *)
  input  logic [W*(d-1)-1:0]                                    i_rnd,
  (* fv_type = "sharing", fv_latency = 0, fv_count = W *)
  output logic [W*d-1:0]                                        o_shares
);

  for (genvar b = 0; b < W; b++) begin : g_bit
    logic [d-2:0] w_rnd_bits;

    for (genvar j = 1; j < d; j++) begin : g_share
      assign w_rnd_bits[j-1] = i_rnd[(j-1)*W + b];
    end

    // Share 0 absorbs the data bit; the XOR is only ever consumed as share 0, never as data.
    assign o_shares[idx(b, 0, d) +: d] = {w_rnd_bits, i_data[b] ^ (^w_rnd_bits)};
  end

endmodule

// File: rtl/msk_share_loader.sv
// Masked share loader: encodes NWORDS unmasked words into a d-share sharing and hands it downstream.
module msk_share_loader
  import msk_share_loader_pkg::*;
#(
  parameter int unsigned d      = 2,
  parameter int unsigned W      = 8,
  parameter int unsigned NWORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [W-1:0]            in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [W*(d-1)-1:0]      rnd,
  input  logic                    rnd_valid,
  output logic                    rnd_ready,
  output logic [W*NWORDS*d-1:0]   out_shares,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int unsigned CW = cnt_width(NWORDS);
  localparam int unsigned SW = W * d;
  localparam logic [CW-1:0] LastWord = CW'(NWORDS - 1);

  state_e        r_state, w_state_next;
  logic [CW-1:0] r_wcnt, w_wcnt_next;
  logic [SW-1:0] w_enc;
  logic          w_fire;

  msk_share_loader_encode #(
    .d (d),
    .W (W)
  ) u_encode (
    .i_data   (in_data),
    .i_rnd    (rnd),
    .o_shares (w_enc)
  );

  assign in_ready  = (r_state == StLoad) & ~rst;
  assign w_fire    = in_valid & rnd_valid & in_ready;
  assign rnd_ready = w_fire;
  assign out_valid = (r_state == StFull);

  always_comb begin
    w_state_next = r_state;
    w_wcnt_next  = r_wcnt;
    unique case (r_state)
      StLoad: begin
        if (w_fire) begin
          if (r_wcnt == LastWord) begin
            w_wcnt_next  = '0;
            w_state_next = StFull;
          end else begin
            w_wcnt_next = r_wcnt + 1'b1;
          end
        end
      end
      StFull: begin
        if (out_ready) begin
          w_state_next = StLoad;
        end
      end
      default: w_state_next = StLoad;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StLoad;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_state_next;
      r_wcnt  <= w_wcnt_next;
    end
  end

  // One register per word slot; slots not yet rewritten keep stale shares until overwritten.
  for (genvar k = 0; k < NWORDS; k++) begin : g_slot
    logic [SW-1:0] r_slot;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_slot <= '0;
      end else if (w_fire && (r_wcnt == CW'(k))) begin
        r_slot <= w_enc;
      end
    end

    assign out_shares[k*SW +: SW] = r_slot;
  end

  a_full_stable: assert property (@(posedge clk) disable iff (rst)
    (r_state == StFull && !out_ready) |=> $stable(out_shares));

  a_no_fire_when_full: assert property (@(posedge clk) disable iff (rst)
    (r_state == StFull) |-> !rnd_ready);

  a_wcnt_range: assert property (@(posedge clk) disable iff (rst)
    r_wcnt <= LastWord);

endmodule
